// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and the IF/ID register.
//   - default address/instruction widths and the PC increment
//   - NOP_INSTR: value shown in a flushed pipeline register
//   - fetch_state_e: fetch controller states
package if_fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register carrying {valid, instruction, pc} between two stages.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   load            capture d_instr/d_pc and mark the entry valid
//   flush           invalidate the entry (instr forced to NOP); wins over load
//   d_instr, d_pc   data to capture on load
//   q_valid, q_instr, q_pc  registered outputs
// With neither load nor flush the register holds (stall).
module if_id_reg #(
  parameter int AW = 32,
  parameter int IW = 32,
  parameter logic [IW-1:0] NOP = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          flush,
  input  logic [IW-1:0] d_instr,
  input  logic [AW-1:0] d_pc,
  output logic          q_valid,
  output logic [IW-1:0] q_instr,
  output logic [AW-1:0] q_pc
);

  logic          valid_d, valid_q;
  logic [IW-1:0] instr_d, instr_q;
  logic [AW-1:0] pc_d, pc_q;

  // Next-state selection: flush, then load, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = d_instr;
      pc_d    = d_pc;
    end else begin
      valid_d = valid_q;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign q_valid = valid_q;
  assign q_instr = instr_q;
  assign q_pc    = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory through a
// req/ack handshake (wait states allowed, one request outstanding) and fills
// the IF/ID register for the decode stage.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   freeze                   hazard stall: hold PC and IF/ID
//   branch_taken/addr        EXE redirect: new PC, flush IF/ID
//   imem_req/addr            fetch request and address
//   imem_ack/rdata           fetch response
//   id_valid/instr/pc        IF/ID contents (id_pc = fetch address + PC_STEP)
module if_fetch_stage #(
  parameter int ADDR_W  = if_fetch_pkg::ADDR_W,
  parameter int INSTR_W = if_fetch_pkg::INSTR_W,
  parameter int PC_STEP = if_fetch_pkg::PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc
);

  import if_fetch_pkg::*;

  fetch_state_e       state_d, state_q;
  logic [ADDR_W-1:0]  pc_d, pc_q;
  logic [ADDR_W-1:0]  req_addr_d, req_addr_q;
  logic [INSTR_W-1:0] hold_buf_d, hold_buf_q;
  logic               ifid_load, ifid_flush;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  pc_inc;

  // Modulo 2^ADDR_W increment, so the top of the address space wraps to 0.
  assign pc_inc = pc_q + ADDR_W'(PC_STEP);

  // Fetch controller: next state, PC, latched request address and IF/ID controls.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    hold_buf_d = hold_buf_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_instr = imem_rdata;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (branch_taken) begin
          pc_d       = branch_addr;
          ifid_flush = 1'b1;
          if (!imem_ack) begin
            // Request is still in flight: remember its address and drain it.
            req_addr_d = pc_q;
            state_d    = ST_DISCARD;
          end else begin
            state_d = ST_FETCH;
          end
        end else if (imem_ack) begin
          if (freeze) begin
            // Data arrived while ID is stalled: park it instead of refetching.
            hold_buf_d = imem_rdata;
            state_d    = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_inc;
          end
        end else if (!freeze) begin
          ifid_flush = 1'b1;  // wait state: present a bubble
        end else begin
          ifid_flush = 1'b0;
        end
      end
      ST_HOLD: begin
        if (branch_taken) begin
          hold_buf_d = '0;
          pc_d       = branch_addr;
          ifid_flush = 1'b1;
          state_d    = ST_FETCH;
        end else if (!freeze) begin
          ifid_load  = 1'b1;
          ifid_instr = hold_buf_q;
          pc_d       = pc_inc;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DISCARD: begin
        if (branch_taken) begin
          pc_d       = branch_addr;
          ifid_flush = 1'b1;
        end else begin
          pc_d = pc_q;
        end
        if (imem_ack) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      hold_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      hold_buf_q <= hold_buf_d;
    end
  end

  assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
  assign imem_addr = (state_q == ST_FETCH) ? pc_q : req_addr_q;

  if_id_reg #(
    .AW  (ADDR_W),
    .IW  (INSTR_W),
    .NOP (INSTR_W'(NOP_INSTR))
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load    (ifid_load),
    .flush   (ifid_flush),
    .d_instr (ifid_instr),
    .d_pc    (pc_inc),
    .q_valid (id_valid),
    .q_instr (id_instr),
    .q_pc    (id_pc)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a default-reset instance exercises the
// handshake, stalls and branches; a second instance starting at 0xFFFFFFFC
// checks PC wrap-around.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  logic        rdata_follow;
  logic [31:0] rdata_val;

  logic        w_freeze = 1'b0;
  logic        w_branch = 1'b0;
  logic [31:0] w_baddr  = 32'h0;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack    = 1'b1;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = rdata_follow ? imem_addr : rdata_val;
  assign w_rdata    = w_addr;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .freeze(w_freeze), .branch_taken(w_branch),
    .branch_addr(w_baddr), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .id_valid(w_valid),
    .id_instr(w_instr), .id_pc(w_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_id(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc);
    check({tag, ".valid"}, {31'd0, id_valid}, {31'd0, v});
    check({tag, ".instr"}, id_instr, ins);
    check({tag, ".pc"}, id_pc, pc);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    imem_ack = 1'b1; rdata_follow = 1'b1; rdata_val = 32'h0;
    tick(); tick();
    // Reset state
    check("rst.req", {31'd0, imem_req}, 32'd0);
    check("rst.addr", imem_addr, 32'h0);
    check_id("rst", 1'b0, 32'h0, 32'h0);
    check("rst.wrap_addr", w_addr, 32'hFFFF_FFFC);

    // Zero-wait streaming, rdata = address
    rst = 1'b0;
    tick();
    check("s.req", {31'd0, imem_req}, 32'd1);
    check("s.addr", imem_addr, 32'h0);
    check("s.valid0", {31'd0, id_valid}, 32'd0);
    check("w.addr0", w_addr, 32'hFFFF_FFFC);
    tick();
    check("w.pc", w_pc, 32'h0);
    check("w.instr", w_instr, 32'hFFFF_FFFC);
    check("w.addr1", w_addr, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      check_id("stream", 1'b1, 32'(4 * k), 32'(4 * k + 4));
    end
    check("stream.addr", imem_addr, 32'h10);

    // Freeze for 3 cycles coinciding with the ack at 0x10
    rdata_follow = 1'b0; rdata_val = 32'hE3A0_1005; freeze = 1'b1;
    tick();
    check("hold.req", {31'd0, imem_req}, 32'd0);
    check_id("hold1", 1'b1, 32'hC, 32'h10);
    imem_ack = 1'b0;
    tick();
    check("hold2.req", {31'd0, imem_req}, 32'd0);
    check_id("hold2", 1'b1, 32'hC, 32'h10);
    tick();
    check_id("hold3", 1'b1, 32'hC, 32'h10);
    freeze = 1'b0;
    tick();
    check_id("release", 1'b1, 32'hE3A0_1005, 32'h14);
    check("release.addr", imem_addr, 32'h14);
    check("release.req", {31'd0, imem_req}, 32'd1);

    // Two wait states on the request at 0x14
    rdata_follow = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("wait.addr", imem_addr, 32'h14);
      check("wait.valid", {31'd0, id_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    tick();
    check_id("wait.done", 1'b1, 32'h14, 32'h18);
    check("wait.next", imem_addr, 32'h18);

    // Branch to 0x100 while the request at 0x20 is outstanding
    tick(); tick();
    check("pre_br.addr", imem_addr, 32'h20);
    imem_ack = 1'b0; branch_taken = 1'b1; branch_addr = 32'h100;
    tick();
    branch_taken = 1'b0;
    check("br.addr", imem_addr, 32'h20);
    check("br.req", {31'd0, imem_req}, 32'd1);
    check_id("br.flush", 1'b0, 32'h0, 32'h20);
    tick();
    check("br.addr2", imem_addr, 32'h20);
    check("br.valid2", {31'd0, id_valid}, 32'd0);
    imem_ack = 1'b1;
    tick();
    check("br.drop_valid", {31'd0, id_valid}, 32'd0);
    check("br.new_addr", imem_addr, 32'h100);
    tick();
    check_id("br.target", 1'b1, 32'h100, 32'h104);

    // Freeze and branch in the same cycle, target 0x40
    freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h40;
    tick();
    branch_taken = 1'b0;
    check("fb.valid", {31'd0, id_valid}, 32'd0);
    check("fb.instr", id_instr, 32'h0);
    check("fb.addr", imem_addr, 32'h40);
    // Frozen bubble, then branch out of HOLD to 0x80
    tick();
    check("hb.req", {31'd0, imem_req}, 32'd0);
    check("hb.valid", {31'd0, id_valid}, 32'd0);
    branch_taken = 1'b1; branch_addr = 32'h80;
    tick();
    branch_taken = 1'b0; freeze = 1'b0;
    check("hb.addr", imem_addr, 32'h80);
    check("hb.req2", {31'd0, imem_req}, 32'd1);
    check("hb.valid2", {31'd0, id_valid}, 32'd0);

    // Reset while waiting on a request
    imem_ack = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("mrst.req", {31'd0, imem_req}, 32'd0);
    check("mrst.addr", imem_addr, 32'h0);
    check_id("mrst", 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    tick();
    check("mrst.fetch", {31'd0, imem_req}, 32'd1);
    check("mrst.fetch_addr", imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
